// File: rtl/hazard_fwd_unit_if.sv
// D-stage decode fields into the hazard unit, and forward selects plus stall/flush controls back out.
// The controller holds the master modport and the hazard unit holds the slave modport.
interface hazard_fwd_unit_if #(
  parameter int REG_BITS = 5
);
  logic                id_valid;
  logic [REG_BITS-1:0] id_rs1;
  logic [REG_BITS-1:0] id_rs2;
  logic [REG_BITS-1:0] id_rd;
  logic                id_regwrite;
  logic                id_is_load;
  logic                pc_src_e;
  logic [1:0]          fwd_a;
  logic [1:0]          fwd_b;
  logic                stall_f;
  logic                stall_d;
  logic                flush_d;
  logic                flush_e;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_is_load, pc_src_e,
    input  fwd_a, fwd_b, stall_f, stall_d, flush_d, flush_e
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_is_load, pc_src_e,
    output fwd_a, fwd_b, stall_f, stall_d, flush_d, flush_e
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding control for the 5-stage RV32I pipeline: outputs are combinational from the E/M/W tag
// shadow and the D-stage fields (zero latency); the tags advance every edge, and a load-use stall holds F/D for one cycle.
module hazard_fwd_unit #(
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  hazard_fwd_unit_if.slave    hz
);

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rs1;
    logic [REG_BITS-1:0] rs2;
    logic [REG_BITS-1:0] rd;
    logic                regwrite;
    logic                is_load;
  } e_ent_t;

  typedef struct packed {
    logic [REG_BITS-1:0] rd;
    logic                regwrite;
  } mw_ent_t;

  e_ent_t  e_q, e_d;
  mw_ent_t m_q, m_d;
  mw_ent_t w_q, w_d;
  logic    lduse;
  logic    flush_e_int;

  // MEM beats WB so that the newest producer wins; x0 and invalid E slots never forward.
  function automatic logic [1:0] fwd_sel(input logic                e_vld,
                                         input logic [REG_BITS-1:0] rs,
                                         input mw_ent_t             m,
                                         input mw_ent_t             w);
    logic [1:0] sel;
    sel = 2'd0;
    if (e_vld && (rs != '0)) begin
      if (m.regwrite && (m.rd == rs))      sel = 2'd2;
      else if (w.regwrite && (w.rd == rs)) sel = 2'd1;
    end
    return sel;
  endfunction

  always_comb begin
    lduse = e_q.valid && e_q.is_load && e_q.regwrite && (e_q.rd != '0) && hz.id_valid &&
            ((e_q.rd == hz.id_rs1) || (e_q.rd == hz.id_rs2));
  end

  assign flush_e_int = lduse | hz.pc_src_e;

  assign hz.fwd_a   = fwd_sel(e_q.valid, e_q.rs1, m_q, w_q);
  assign hz.fwd_b   = fwd_sel(e_q.valid, e_q.rs2, m_q, w_q);
  assign hz.stall_f = lduse & ~hz.pc_src_e;
  assign hz.stall_d = lduse & ~hz.pc_src_e;
  assign hz.flush_d = hz.pc_src_e;
  assign hz.flush_e = flush_e_int;

  always_comb begin
    e_d = '0;
    if (!flush_e_int) begin
      e_d.valid    = hz.id_valid;
      e_d.rs1      = hz.id_rs1;
      e_d.rs2      = hz.id_rs2;
      e_d.rd       = hz.id_rd;
      e_d.regwrite = hz.id_regwrite;
      e_d.is_load  = hz.id_is_load;
    end
    m_d.rd       = e_q.rd;
    m_d.regwrite = e_q.regwrite;
    w_d          = m_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: directed pipeline scenarios plus a constrained random run.
module tb_hazard_fwd_unit;
  localparam int RB = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.REG_BITS(RB)) hz ();
  hazard_fwd_unit #(.REG_BITS(RB)) dut (.clk(clk), .reset(reset), .hz(hz));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference tag pipeline kept by the bench.
  logic          me_valid, me_rw, me_ld;
  logic [RB-1:0] me_rs1, me_rs2, me_rd;
  logic [RB-1:0] mm_rd, mw_rd;
  logic          mm_rw, mw_rw;

  logic [7:0] exp_q[$];
  logic [7:0] obs;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] mfwd(input logic [RB-1:0] rs);
    if (!me_valid || rs == '0)       return 2'd0;
    if (mm_rw && mm_rd == rs)        return 2'd2;
    if (mw_rw && mw_rd == rs)        return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_clear();
    me_valid = 0; me_rw = 0; me_ld = 0;
    me_rs1 = '0; me_rs2 = '0; me_rd = '0;
    mm_rd = '0; mm_rw = 0; mw_rd = '0; mw_rw = 0;
  endtask

  // One clock: drive D fields, predict and compare outputs, then advance the model on the edge.
  task automatic step(input logic rst, input logic v, input logic [RB-1:0] rs1, input logic [RB-1:0] rs2,
                      input logic [RB-1:0] rd, input logic rw, input logic ld, input logic br);
    logic       lu;
    logic       fe;
    logic [7:0] ev;
    reset = rst;
    hz.id_valid = v; hz.id_rs1 = rs1; hz.id_rs2 = rs2; hz.id_rd = rd;
    hz.id_regwrite = rw; hz.id_is_load = ld; hz.pc_src_e = br;
    #1;
    lu = me_valid && me_ld && me_rw && (me_rd != '0) && v && ((me_rd == rs1) || (me_rd == rs2));
    fe = lu || br;
    ev = {mfwd(me_rs1), mfwd(me_rs2), lu && !br, lu && !br, br, fe};
    exp_q.push_back(ev);
    obs = {hz.fwd_a, hz.fwd_b, hz.stall_f, hz.stall_d, hz.flush_d, hz.flush_e};
    if (exp_q.size() != 0) check_val("outputs", {24'd0, obs}, {24'd0, exp_q.pop_front()});
    @(posedge clk);
    if (rst) model_clear();
    else begin
      mw_rd = mm_rd; mw_rw = mm_rw;
      mm_rd = me_rd; mm_rw = me_rw;
      if (fe) begin
        me_valid = 0; me_rw = 0; me_ld = 0; me_rs1 = '0; me_rs2 = '0; me_rd = '0;
      end else begin
        me_valid = v; me_rs1 = rs1; me_rs2 = rs2; me_rd = rd; me_rw = rw; me_ld = ld;
      end
    end
    #1;
  endtask

  task automatic nop();
    step(0, 0, '0, '0, '0, 0, 0, 0);
  endtask

  task automatic ins(input logic [RB-1:0] rs1, input logic [RB-1:0] rs2, input logic [RB-1:0] rd,
                     input logic rw, input logic ld);
    step(0, 1, rs1, rs2, rd, rw, ld, 0);
  endtask

  task automatic drain();
    repeat (3) nop();
  endtask

  initial begin
    reset = 1;
    hz.id_valid = 0; hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_rd = '0;
    hz.id_regwrite = 0; hz.id_is_load = 0; hz.pc_src_e = 0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    step(1, 0, '0, '0, '0, 0, 0, 0);

    nop();
    check_val("reset_out", {24'd0, obs}, 32'd0);

    // Back-to-back RAW: producer in M when consumer is in E.
    ins(5'd1, 5'd2, 5'd5, 1, 0);
    ins(5'd5, 5'd6, 5'd8, 1, 0);
    nop();
    check_val("raw_mem_fwd_a", {30'd0, obs[7:6]}, 32'd2);
    drain();

    // One instruction between: producer in W.
    ins(5'd1, 5'd2, 5'd5, 1, 0);
    nop();
    ins(5'd5, 5'd3, 5'd9, 1, 0);
    nop();
    check_val("raw_wb_fwd_a", {30'd0, obs[7:6]}, 32'd1);
    drain();

    // x5 in both M and W: newest wins.
    ins(5'd1, 5'd2, 5'd5, 1, 0);
    ins(5'd3, 5'd4, 5'd5, 1, 0);
    ins(5'd6, 5'd5, 5'd10, 1, 0);
    nop();
    check_val("mem_prio_fwd_b", {30'd0, obs[5:4]}, 32'd2);
    drain();

    // Load-use on rs2: one stall, then WB forward.
    ins(5'd1, 5'd0, 5'd7, 1, 1);
    ins(5'd3, 5'd7, 5'd11, 1, 0);
    check_val("lduse_ctl", {28'd0, obs[3:0]}, 32'b1101);
    ins(5'd3, 5'd7, 5'd11, 1, 0);
    check_val("lduse_once", {28'd0, obs[3:0]}, 32'd0);
    nop();
    check_val("lduse_fwd_b", {30'd0, obs[5:4]}, 32'd1);
    drain();

    // Load-use coinciding with a taken branch.
    ins(5'd1, 5'd0, 5'd7, 1, 1);
    step(0, 1, 5'd7, 5'd0, 5'd12, 1, 0, 1);
    check_val("br_over_lduse", {28'd0, obs[3:0]}, 32'b0011);
    nop();
    check_val("br_bubble_fwd", {28'd0, obs[7:4]}, 32'd0);
    drain();

    // x0 producers never forward or stall.
    ins(5'd1, 5'd2, 5'd0, 1, 0);
    ins(5'd0, 5'd0, 5'd13, 1, 0);
    nop();
    check_val("x0_fwd_a", {30'd0, obs[7:6]}, 32'd0);
    ins(5'd1, 5'd2, 5'd0, 1, 1);
    ins(5'd0, 5'd3, 5'd14, 1, 0);
    check_val("x0_no_stall", {28'd0, obs[3:0]}, 32'd0);
    drain();

    // Reset in the middle of a load-use stall.
    ins(5'd1, 5'd0, 5'd7, 1, 1);
    step(1, 1, 5'd7, 5'd0, 5'd15, 1, 0, 0);
    check_val("stall_before_rst", {31'd0, obs[3]}, 32'd1);
    ins(5'd7, 5'd0, 5'd15, 1, 0);
    check_val("post_reset_out", {24'd0, obs}, 32'd0);
    nop();
    check_val("post_reset_tags", {24'd0, obs}, 32'd0);
    drain();

    // Dense random traffic on a small register window.
    for (int i = 0; i < 400; i++) begin
      logic v, rw, ld, br, rst;
      v   = ($urandom_range(0, 3) != 0);
      rw  = v && ($urandom_range(0, 3) != 0);
      ld  = rw && ($urandom_range(0, 2) == 0);
      br  = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 49) == 0);
      step(rst, v, RB'($urandom_range(0, 3)), RB'($urandom_range(0, 3)), RB'($urandom_range(0, 3)), rw, ld, br);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
